// File: rtl/divf_seq.sv
// Sequential IEEE-754 single-precision divider: radix-2 restoring mantissa
// division, one quotient bit per clock, truncating, denormals flushed to zero.
module divf_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [EXP_W+MANT_W:0]     a,
    input  logic [EXP_W+MANT_W:0]     b,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+MANT_W:0]     s
);
    localparam int W    = 1 + EXP_W + MANT_W;
    localparam int ITER = MANT_W + 2;
    localparam int CW   = $clog2(ITER);
    localparam int EW   = EXP_W + 2;
    localparam logic signed [EW-1:0] EMAX = EW'((2**EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spc_t;

    state_t                 state, nxt;
    spc_t                   spc;
    logic [CW-1:0]          cnt;
    logic [MANT_W+1:0]      rem, rdiff, rnext;
    logic [MANT_W:0]        mb;
    logic [ITER-1:0]        q;
    logic signed [EW-1:0]   ex, exn;
    logic                   sgn, ge;
    logic [MANT_W-1:0]      mant;
    logic [W-1:0]           res;

    logic [EXP_W-1:0] ae, be;
    assign ae = a[W-2:MANT_W];
    assign be = b[W-2:MANT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = DIV;
            DIV:     if (cnt == CW'(ITER - 1)) nxt = NORM;
            NORM:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // One restoring step: subtract when the partial remainder covers the divisor.
    assign ge    = (rem >= {1'b0, mb});
    assign rdiff = rem - {1'b0, mb};
    assign rnext = ge ? (rdiff << 1) : (rem << 1);

    always_comb begin
        mant = q[ITER-1] ? q[ITER-2:1] : q[ITER-3:0];
        exn  = q[ITER-1] ? ex : ex - EW'(1);
        res  = {sgn, {EXP_W{1'b0}}, mant};
        if (exn >= EMAX)            res = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else if (exn <= EW'(0))     res = {sgn, {(W-1){1'b0}}};
        else                        res = {sgn, exn[EXP_W-1:0], mant};
        case (spc)
            SP_NAN:  res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
            SP_INF:  res = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            SP_ZERO: res = {sgn, {(W-1){1'b0}}};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            rem  <= '0;
            mb   <= '0;
            q    <= '0;
            ex   <= '0;
            sgn  <= 1'b0;
            spc  <= SP_NONE;
            done <= 1'b0;
            s    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sgn <= a[W-1] ^ b[W-1];
                    rem <= {2'b01, a[MANT_W-1:0]};
                    mb  <= {1'b1, b[MANT_W-1:0]};
                    q   <= '0;
                    cnt <= '0;
                    ex  <= EW'({2'b00, ae}) - EW'({2'b00, be}) + EW'(BIAS);
                    // Specials are resolved now; the datapath still runs for fixed latency.
                    if (ae == '1 || be == '1 || (ae == '0 && be == '0)) spc <= SP_NAN;
                    else if (be == '0)                                  spc <= SP_INF;
                    else if (ae == '0)                                  spc <= SP_ZERO;
                    else                                                spc <= SP_NONE;
                end
                DIV: begin
                    rem <= rnext;
                    q   <= {q[ITER-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    s    <= res;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divf_seq.sv
// Scoreboarded bench for divf_seq: directed corner cases plus random operands
// checked against an integer-division reference model.
module tb_divf_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] s;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct { logic [31:0] s; int cyc; } exp_t;
    exp_t sb[$];

    divf_seq dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                  .busy(busy), .done(done), .s(s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        int ea, eb, e;
        logic sg;
        longint unsigned ma, mb, qq;
        logic [22:0] m;
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        sg = x[31] ^ y[31];
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) return 32'h7FC00000;
        if (eb == 0) return {sg, 8'hFF, 23'h0};
        if (ea == 0) return {sg, 31'h0};
        ma = 64'(x[22:0]) + 64'h800000;
        mb = 64'(y[22:0]) + 64'h800000;
        qq = (ma << 24) / mb;
        e  = ea - eb + 127;
        if (qq >= 64'h1000000) m = qq[23:1];
        else begin
            m = qq[22:0];
            e = e - 1;
        end
        if (e >= 255) return {sg, 8'hFF, 23'h0};
        if (e <= 0)   return {sg, 31'h0};
        return {sg, e[7:0], m};
    endfunction

    // Monitor: every done must match the oldest outstanding op, value and latency.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", s, e.s);
                chk("latency", 32'(cyc - e.cyc), 32'd26);
            end
        end
    end

    // Call at a negedge with the DUT idle (or in its done cycle).
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit track);
        exp_t e;
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e.s = ref_div(x, y);
        e.cyc = cyc;
        if (track) sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 60) chk("done_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        int r;
        logic [7:0] e;
        r = $urandom_range(0, 15);
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else if (r < 4)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), e, 23'($urandom())};
    endfunction

    logic [31:0] dir_a [10] = '{32'h40C00000, 32'h3F800000, 32'hBFC00000, 32'h3F800000, 32'h00000000,
                               32'h80000000, 32'h7F800000, 32'h7F000000, 32'h00800000, 32'h3F800000};
    logic [31:0] dir_b [10] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000, 32'h00000000,
                               32'h40A00000, 32'h3F800000, 32'h00800000, 32'h7F000000, 32'h3F800000};
    logic [31:0] dir_s [10] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000, 32'h7FC00000,
                               32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h3F800000};

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_s", s, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 6/2 with busy-duration and done-cycle busy checks
        issue(32'h40C00000, 32'h40000000, 1'b1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) n++;
        end
        chk("busy_cycles", 32'(n), 32'd26);
        chk("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("s_held", s, 32'h40400000);

        // Directed table, also checked against the model's own rules
        for (int i = 0; i < 10; i++) begin
            chk("model_table", ref_div(dir_a[i], dir_b[i]), dir_s[i]);
            issue(dir_a[i], dir_b[i], 1'b1);
            wait_done();
            if (i == 1) chk("one_third", s, 32'h3EAAAAAA);
            @(negedge clk);
        end

        // Start while busy with new operands is ignored
        issue(32'h40C00000, 32'h40000000, 1'b1);
        repeat (4) @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        wait_done();
        @(negedge clk);
        chk("ignored_start", 32'(busy), 32'd0);

        // Reset mid-operation aborts it
        issue(32'h3F800000, 32'h40400000, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", s, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Back-to-back: start issued during the done cycle
        issue(32'h40C00000, 32'h40000000, 1'b1);
        wait_done();
        issue(32'hBFC00000, 32'h3F000000, 1'b1);
        wait_done();

        // Random operands, each launched in the previous op's done cycle
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            issue(rnd_op(), rnd_op(), 1'b1);
            wait_done();
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
